// File: rtl/mas_mul_share_arb_if.sv
// rtl/mas_mul_share_arb_if.sv - requester, core and response bundle for the shared multiplier arbiter
interface mas_mul_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_in1;
  logic [NREQ*32-1:0] req_in2;
  logic [31:0]        mul_in1;
  logic [31:0]        mul_in2;
  logic [63:0]        mul_res;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [63:0]        rsp_res;
  logic               busy;
  logic [IDW+1:0]     inflight;

  modport slave (
    input  req_valid, req_in1, req_in2, mul_res,
    output req_ready, mul_in1, mul_in2, rsp_valid, rsp_id, rsp_res, busy, inflight
  );

  modport master (
    output req_valid, req_in1, req_in2, mul_res,
    input  req_ready, mul_in1, mul_in2, rsp_valid, rsp_id, rsp_res, busy, inflight
  );
endinterface

// File: rtl/mas_mul_share_arb.sv
// rtl/mas_mul_share_arb.sv - round-robin arbiter time-sharing one pipelined 32x32 multiplier core
module mas_mul_share_arb #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2,
  parameter int IDW     = 2
) (
  input logic clk,
  input logic rst,
  mas_mul_share_arb_if.slave bus
);
  localparam logic [IDW+1:0] inf_one = 1;

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  idx;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  ptr_nxt;
  logic            found;
  logic            fire;
  logic [NREQ-1:0] grant;
  logic [31:0]     win_in1;
  logic [31:0]     win_in2;
  logic [31:0]     mul_in1_q;
  logic [31:0]     mul_in2_q;
  logic [MUL_LAT:0] tag_vld;
  logic [IDW-1:0]  tag_id [MUL_LAT+1];
  logic [IDW+1:0]  inflight_q;

  // Scan from ptr with wrap; first requester found wins.
  always_comb begin
    found   = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    grant   = '0;
    win_in1 = '0;
    win_in2 = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (found && gnt_id == IDW'(j)) begin
        grant[j] = ~rst;
        win_in1  = bus.req_in1[32*j +: 32];
        win_in2  = bus.req_in2[32*j +: 32];
      end
    end
  end

  assign fire    = found && !rst;
  assign ptr_nxt = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      mul_in1_q  <= '0;
      mul_in2_q  <= '0;
      tag_vld    <= '0;
      inflight_q <= '0;
      for (int s = 0; s <= MUL_LAT; s++) tag_id[s] <= '0;
    end else begin
      if (fire) begin
        ptr       <= ptr_nxt;
        mul_in1_q <= win_in1;
        mul_in2_q <= win_in2;
        tag_id[0] <= gnt_id;
      end
      // Stage 0 covers the operand register, the rest track the core latency.
      tag_vld <= {tag_vld[MUL_LAT-1:0], fire};
      for (int s = 1; s <= MUL_LAT; s++) tag_id[s] <= tag_id[s-1];
      case ({fire, tag_vld[MUL_LAT]})
        2'b10:   inflight_q <= inflight_q + inf_one;
        2'b01:   inflight_q <= inflight_q - inf_one;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.mul_in1   = mul_in1_q;
  assign bus.mul_in2   = mul_in2_q;
  assign bus.rsp_valid = tag_vld[MUL_LAT];
  assign bus.rsp_id    = tag_id[MUL_LAT];
  assign bus.rsp_res   = tag_vld[MUL_LAT] ? bus.mul_res : 64'd0;
  assign bus.inflight  = inflight_q;
  assign bus.busy      = (inflight_q != '0);
endmodule

// File: tb/tb_mas_mul_share_arb.sv
// tb/tb_mas_mul_share_arb.sv - directed self-checking bench for the shared multiplier arbiter
module tb_mas_mul_share_arb;
  localparam int NREQ    = 4;
  localparam int MUL_LAT = 2;
  localparam int IDW     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [63:0] pipe [MUL_LAT];

  mas_mul_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mas_mul_share_arb #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural pipelined multiplier core with MUL_LAT register stages.
  always_ff @(posedge clk) begin
    pipe[0] <= {32'd0, bus.mul_in1} * {32'd0, bus.mul_in2};
    for (int s = 1; s < MUL_LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign bus.mul_res = pipe[MUL_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_in1 = {32'd4, 32'd3, 32'd2, 32'd1};
    bus.req_in2 = {32'd4, 32'd3, 32'd2, 32'd1};
    tick();
    tick();
    n_checks++; if (bus.req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready got=%h exp=0", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got=%h exp=0", bus.rsp_id); end
    n_checks++; if (bus.rsp_res !== 64'd0) begin n_fail++; $display("FAIL reset_rsp_res got=%h exp=0", bus.rsp_res); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.inflight !== 4'd0) begin n_fail++; $display("FAIL reset_inflight got=%0d exp=0", bus.inflight); end
    n_checks++; if (bus.mul_in1 !== 32'd0 || bus.mul_in2 !== 32'd0) begin n_fail++; $display("FAIL reset_mul_in got=%h/%h exp=0/0", bus.mul_in1, bus.mul_in2); end
    bus.req_valid = '0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    bus.req_in1 = {32'd0, 32'd0, 32'd0, 32'h0000_0003};
    bus.req_in2 = {32'd0, 32'd0, 32'd0, 32'h0000_0005};
    bus.req_valid = 4'b0001;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #1;
    n_checks++; if (bus.inflight !== 4'd1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_inflight1 got=%0d/%b exp=1/1", bus.inflight, bus.busy); end
    n_checks++; if (bus.mul_in1 !== 32'd3 || bus.mul_in2 !== 32'd5) begin n_fail++; $display("FAIL single_operands got=%h/%h exp=3/5", bus.mul_in1, bus.mul_in2); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early1 got=%b exp=0", bus.rsp_valid); end
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early2 got=%b exp=0", bus.rsp_valid); end
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got=%b exp=1", bus.rsp_valid); end
    n_checks++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_rsp_id got=%0d exp=0", bus.rsp_id); end
    n_checks++; if (bus.rsp_res !== 64'd15) begin n_fail++; $display("FAIL single_rsp_res got=%h exp=15", bus.rsp_res); end
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_drop got=%b exp=0", bus.rsp_valid); end
    n_checks++; if (bus.inflight !== 4'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_inflight0 got=%0d/%b exp=0/0", bus.inflight, bus.busy); end
    n_checks++; if (bus.rsp_res !== 64'd0) begin n_fail++; $display("FAIL single_res_gated got=%h exp=0", bus.rsp_res); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_ready;
    logic [1:0]  exp_id;
    logic [3:0]  exp_inf;
    logic [63:0] exp_res;
    do_reset();
    bus.req_in1 = {32'd4, 32'd3, 32'd2, 32'd1};
    bus.req_in2 = {32'd40, 32'd30, 32'd20, 32'd10};
    bus.req_valid = 4'hF;
    #1;
    for (int k = 0; k < 10; k++) begin
      exp_ready = 4'b0001 << (k % 4);
      exp_inf   = (k < 3) ? 4'(k) : 4'd3;
      n_checks++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, bus.req_ready, exp_ready); end
      n_checks++; if (bus.inflight !== exp_inf) begin n_fail++; $display("FAIL rr_inflight[%0d] got=%0d exp=%0d", k, bus.inflight, exp_inf); end
      n_checks++; if (bus.rsp_valid !== (k >= 3)) begin n_fail++; $display("FAIL rr_rsp_valid[%0d] got=%b exp=%b", k, bus.rsp_valid, k >= 3); end
      if (k >= 3) begin
        exp_id  = 2'((k - 3) % 4);
        exp_res = 64'((int'(exp_id) + 1) * (int'(exp_id) + 1) * 10);
        n_checks++; if (bus.rsp_id !== exp_id) begin n_fail++; $display("FAIL rr_rsp_id[%0d] got=%0d exp=%0d", k, bus.rsp_id, exp_id); end
        n_checks++; if (bus.rsp_res !== exp_res) begin n_fail++; $display("FAIL rr_rsp_res[%0d] got=%0d exp=%0d", k, bus.rsp_res, exp_res); end
      end
      tick();
    end
    bus.req_valid = '0;
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (bus.inflight !== 4'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rr_drain got=%0d/%b exp=0/0", bus.inflight, bus.busy); end
  endtask

  task automatic test_max_operands();
    do_reset();
    bus.req_in1 = {32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
    bus.req_in2 = {32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
    bus.req_valid = 4'b0100;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL max_ready got=%b exp=0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2) begin n_fail++; $display("FAIL max_rsp got=%b/%0d exp=1/2", bus.rsp_valid, bus.rsp_id); end
    n_checks++; if (bus.rsp_res !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL max_res got=%h exp=fffffffe00000001", bus.rsp_res); end
    tick();
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    bus.req_in1 = {32'd7, 32'd6, 32'd5, 32'd4};
    bus.req_in2 = {32'd2, 32'd2, 32'd2, 32'd2};
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'b1010;
    #1;
    n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_first got=%b exp=1000", bus.req_ready); end
    tick();
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_second got=%b exp=0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0010;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_search got=%b exp=0010", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_res !== 64'd12) begin n_fail++; $display("FAIL wrap_rsp0 got=%b/%0d/%0d exp=1/2/12", bus.rsp_valid, bus.rsp_id, bus.rsp_res); end
    tick();
    bus.req_valid = '0;
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_res !== 64'd14) begin n_fail++; $display("FAIL wrap_rsp1 got=%b/%0d/%0d exp=1/3/14", bus.rsp_valid, bus.rsp_id, bus.rsp_res); end
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_res !== 64'd10) begin n_fail++; $display("FAIL wrap_rsp2 got=%b/%0d/%0d exp=1/1/10", bus.rsp_valid, bus.rsp_id, bus.rsp_res); end
    for (int k = 0; k < 3; k++) tick();
    n_checks++; if (bus.inflight !== 4'd0) begin n_fail++; $display("FAIL wrap_drain got=%0d exp=0", bus.inflight); end
  endtask

  task automatic test_reset_midflight();
    int seen;
    do_reset();
    bus.req_in1 = {32'd1, 32'd1, 32'd1, 32'd1};
    bus.req_in2 = {32'd1, 32'd1, 32'd1, 32'd1};
    bus.req_valid = 4'b0111;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ready0 got=%b exp=0001", bus.req_ready); end
    tick();
    n_checks++; if (bus.req_ready !== 4'b0010 || bus.inflight !== 4'd1) begin n_fail++; $display("FAIL mid_ready1 got=%b/%0d exp=0010/1", bus.req_ready, bus.inflight); end
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready_rst got=%b exp=0000", bus.req_ready); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.inflight !== 4'd0 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_cleared got=%0d/%b/%b exp=0/0/0", bus.inflight, bus.busy, bus.rsp_valid); end
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr got=%b exp=0001", bus.req_ready); end
    bus.req_valid = '0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (bus.rsp_valid === 1'b1) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_rsp got=%0d exp=0", seen); end
  endtask

  task automatic test_withdraw();
    int id1_seen;
    int rsp_seen;
    do_reset();
    bus.req_in1 = {32'd0, 32'd0, 32'd9, 32'd6};
    bus.req_in2 = {32'd0, 32'd0, 32'd9, 32'd7};
    bus.req_valid = 4'b0011;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL wd_ready got=%b exp=0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL wd_idle got=%b exp=0000", bus.req_ready); end
    id1_seen = 0;
    rsp_seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.rsp_valid === 1'b1) begin
        rsp_seen++;
        if (bus.rsp_id === 2'd1) id1_seen++;
        n_checks++; if (bus.rsp_res !== 64'd42) begin n_fail++; $display("FAIL wd_res got=%0d exp=42", bus.rsp_res); end
      end
      tick();
    end
    n_checks++; if (rsp_seen !== 1 || id1_seen !== 0) begin n_fail++; $display("FAIL wd_rsp_count got=%0d/%0d exp=1/0", rsp_seen, id1_seen); end
    bus.req_valid = 4'b0011;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL wd_ptr got=%b exp=0010", bus.req_ready); end
    bus.req_valid = '0;
    tick();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_max_operands();
    test_ptr_wrap();
    test_reset_midflight();
    test_withdraw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mas_mul_share_arb.md
Name: mas_mul_share_arb

Overview:
- Round-robin arbiter that time-shares one pipelined 32x32 multiplier core (mas_mul_vedic_32x32 or any core with the same in1/in2/res interface) among NREQ requesters.
- Each requester presents operands with a valid/ready handshake.
- The block accepts at most one operation per cycle, drives the core's operands, and tracks the issuing requester through a tag pipeline matched to the core latency.
- It returns each 64-bit product to its requester, tagged with the requester index.

Parameters:
- NREQ, 4, number of requesters (2..8)
- MUL_LAT, 2, core latency in cycles from in1/in2 sampled to res valid (>=1)
- IDW, 2, requester index width, $clog2(NREQ)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester operation request
- req_ready  output  NREQ  per-requester grant; one-hot or zero
- req_in1  input  NREQ*32  packed operand A, requester i at [32*i+:32]
- req_in2  input  NREQ*32  packed operand B, same packing
- mul_in1  output  32  operand A to core in1
- mul_in2  output  32  operand B to core in2
- mul_res  input  64  product from core res
- rsp_valid  output  1  product valid this cycle
- rsp_id  output  IDW  requester index owning rsp_res
- rsp_res  output  64  product (copy of mul_res when rsp_valid)
- busy  output  1  any operation in flight
- inflight  output  IDW+2  number of operations issued, not yet returned

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst. All state updates on posedge clk. rst sampled high clears all state that cycle.
- Reset values:
  - req_ready=0, mul_in1=0, mul_in2=0, rsp_valid=0, rsp_id=0, rsp_res=0, busy=0, inflight=0.
  - Round-robin pointer = 0.
  - Tag pipeline cleared (all valid bits 0).
- Arbitration:
  - Combinational. Scan req_valid starting at index ptr, wrapping modulo NREQ.
  - The first set bit wins; req_ready has that single bit set.
  - If no req_valid is set, req_ready=0.
  - req_ready is forced 0 while rst=1.
  - Handshake fires when req_valid[i] && req_ready[i].
- Pointer update:
  - On a fire by requester g, ptr <= (g+1) mod NREQ.
  - With no fire, ptr holds.
- Issue:
  - On a fire, mul_in1/mul_in2 register req_in1/req_in2 of the winner at the clock edge.
  - They hold their last value when idle; the core computes garbage, which is ignored.
  - Tag stage 0 <= {1, g} on a fire, else {0, hold id}.
- Tag pipeline:
  - MUL_LAT+1 stages of {vld, id} shift every cycle: 1 cycle for the operand register plus MUL_LAT for the core.
  - rsp_valid and rsp_id are the final stage.
  - rsp_res = mul_res combinationally, gated to 0 when rsp_valid=0.
  - Total latency from fire edge to rsp_valid high is MUL_LAT+1 cycles.
- Throughput: one fire per cycle sustained; no response backpressure. Requesters must consume rsp in the cycle it is valid.
- inflight:
  - +1 on fire, -1 on rsp_valid; both in the same cycle leaves it unchanged.
  - Maximum value MUL_LAT+1.
  - busy = (inflight != 0).
- Fairness: a continuously requesting requester is granted at least once every NREQ cycles.
- Request withdrawal: req_valid may drop without a fire; no state changes.
- Reset mid-operation: all in-flight tags are discarded and no rsp_valid is produced for them. The core's in-flight results are ignored.
- Operands are unsigned; the product is the full 64 bits, with no truncation.

Test Plan:
- Single requester 0, in1=32'h0000_0003, in2=32'h0000_0005, one fire -> exactly MUL_LAT+1 cycles later rsp_valid=1, rsp_id=0, rsp_res=64'd15; inflight rises to 1 and returns to 0; busy follows.
- All 4 requesters hold req_valid continuously after reset -> grants in order 0,1,2,3,0,...; one fire per cycle; responses return in the same order with matching ids; inflight saturates at MUL_LAT+1.
- Max operands: requester 2 issues in1=in2=32'hFFFF_FFFF -> rsp_res=64'hFFFF_FFFE_0000_0001, rsp_id=2.
- Pointer wrap: ptr=3 with requesters 1 and 3 valid -> 3 granted first, then 1. Only requester 1 valid while ptr=2 -> 1 granted in the same cycle (wrap search).
- Reset mid-flight: issue 3 back-to-back ops, assert rst for 1 cycle before the first response -> no rsp_valid ever appears for them; inflight=0, ptr=0, req_ready=0 during rst.
- Idle gaps and withdrawal: requester 1 asserts req_valid for 1 cycle while requester 0 wins, then drops -> no fire for 1, no response with id 1, ptr advances only on fires.
